serial_adder: RTL and testbench

- Bit-serial, LSB-first adder that consumes one full-adder result per clock.
- Each step's carry-out is registered and fed back as the next step's carry-in.
- Sits directly downstream of the half-adder cell: two half adders form the per-bit full adder, and this block sequences them over a WIDTH-bit operand pair.
- Start/busy/done handshake; the result is held until the next operation.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_fa.sv | 28 ++
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_fa.sv
// Combinational full adder assembled from two half-adder cells plus an OR for the carry.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule : half_adder

module serial_fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);
  logic p;
  logic g_xy;
  logic g_pc;

  half_adder u_ha_xy (.x(x), .y(y),   .s(p), .c(g_xy));
  half_adder u_ha_pc (.x(p), .y(cin), .s(s), .c(g_pc));

  // At most one of the two half-adder carries can be set, so OR equals the sum.
  assign co = g_xy | g_pc;
endmodule : serial_fa

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one full-adder step per clock, start/busy/done handshake,
// result held in sum/cout until the next operation completes.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sb_reg;
  logic [WIDTH-2:0] r_reg;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic             fa_s, fa_co;
  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] r_shift;

  serial_fa u_fa (
    .x  (sa_reg[0]),
    .y  (sb_reg[0]),
    .cin(carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  // A new request is taken in IDLE and also in DONE for back-to-back operation.
  assign accept    = start && (state_reg != ST_RUN);
  assign last_step = (state_reg == ST_RUN) && (count_reg == LAST_BIT);
  // Only the upper WIDTH-1 partial bits are kept; the new bit enters at the MSB.
  assign r_shift   = {fa_s, r_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_reg    <= '0;
      sb_reg    <= '0;
      r_reg     <= '0;
      carry_reg <= 1'b0;
      count_reg <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      sa_reg    <= a;
      sb_reg    <= b;
      r_reg     <= '0;
      carry_reg <= 1'b0;
      count_reg <= '0;
    end else if (state_reg == ST_RUN) begin
      sa_reg    <= sa_reg >> 1;
      sb_reg    <= sb_reg >> 1;
      r_reg     <= r_shift[WIDTH-1:1];
      carry_reg <= fa_co;
      if (last_step) begin
        count_reg <= '0;
        sum_reg   <= r_shift;
        cout_reg  <= fa_co;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder using a result scoreboard popped on each done pulse.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  logic [W:0] sb_q[$];
  int vectors = 0;
  int miscompares = 0;
  int done_count = 0;
  int expected_dones = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      done_count++;
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_done observed={cout,sum}=%0d expected=no_done", {cout, sum});
      end else begin
        logic [W:0] exp_v;
        exp_v = sb_q.pop_front();
        chk("result", {23'd0, cout, sum}, {23'd0, exp_v});
        $display("op result {cout,sum}=%0d expected=%0d", {cout, sum}, exp_v);
      end
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a = av;
    b = bv;
    sb_q.push_back({1'b0, av} + {1'b0, bv});
    expected_dones++;
  endtask

  // Returns at the negedge where done is high, or flags a timeout.
  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < W + 4) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $error("FAIL done_timeout observed=0 expected=1");
    end
  endtask

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv);
    issue(av, bv);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_sum", {24'd0, sum}, 0);
    chk("reset_cout", {31'd0, cout}, 0);
    repeat (4) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 0);
    end

    // 3+5 with cycle-exact latency checks.
    issue(8'd3, 8'd5);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("run_busy", {31'd0, busy}, 1);
      chk("run_done", {31'd0, done}, 0);
      chk("run_sum_held", {24'd0, sum}, 0);
      @(negedge clk);
    end
    chk("done_pulse", {31'd0, done}, 1);
    chk("done_busy", {31'd0, busy}, 0);
    chk("done_sum", {24'd0, sum}, 8);
    chk("done_cout", {31'd0, cout}, 0);
    @(negedge clk);
    chk("done_single", {31'd0, done}, 0);
    repeat (3) @(negedge clk);
    chk("sum_hold", {24'd0, sum}, 8);

    op(8'd255, 8'd1);
    op(8'd200, 8'd100);
    op(8'd0, 8'd0);

    // start mid-RUN must be ignored.
    issue(8'd3, 8'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    a = 8'd1;
    b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // Back-to-back: start held high through the DONE cycle.
    issue(8'd1, 8'd1);
    @(negedge clk);
    chk("b2b_done_deassert", {31'd0, done}, 0);
    chk("b2b_busy", {31'd0, busy}, 1);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // Reset in the middle of 200+100.
    issue(8'd200, 8'd100);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    expected_dones--;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_sum", {24'd0, sum}, 0);
    chk("abort_cout", {31'd0, cout}, 0);
    repeat (W + 2) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 0);
    end
    op(8'd7, 8'd9);
    chk("post_abort_sum", {24'd0, sum}, 16);

    for (int i = 0; i < 200; i++) begin
      op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    end

    repeat (3) @(negedge clk);
    chk("done_count", done_count, expected_dones);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_serial_adder
